imem_browse_ctrl: RTL and testbench
===================================

// Module: imem_browse_ctrl
// PURPOSE
// Controller that walks the instruction memory for on-board inspection. It debounces
// next/prev buttons and steps a registered IMem address, with optional auto-scan.
// It latches the fetched 32-bit word and alternates its low/high halves onto the
// 16-bit seven-segment input. It sits between the board buttons, IMem (combinational
// read) and SevenSegmentTop.
// PARAMETERS
// ADDR_WIDTH       6           IMem word-address width; address range 0..2**ADDR_WIDTH-1
// DEBOUNCE_CYCLES  1_000_000   cycles a synchronised button level must hold before acceptance (>=2)
// SCAN_PERIOD      100_000_000 cycles between automatic address increments (>=4)
// HALF_PERIOD      50_000_000  cycles each half-word is shown before toggling (>=2)
// PORTS
// clk              in   1            single system clock; all logic on rising edge
// reset            in   1            synchronous, active-high reset
// btn_next         in   1            raw asynchronous button: step address +1
// btn_prev         in   1            raw asynchronous button: step address -1
// auto_en          in   1            1 = auto-scan enabled (level, synchronised internally)
// imem_addr        out  ADDR_WIDTH   registered address driven to IMem
// imem_rdata       in   32           IMem combinational read data for imem_addr
// displayed_number out  16           word_q[15:0] when half_sel=0, word_q[31:16] when 1
// half_sel         out  1            which half is displayed (0 = low)
// wrap             out  1            one-cycle pulse when the address wraps in either direction
// BEHAVIOUR
// - Reset: imem_addr=0, word_q=0, half_sel=0, wrap=0. All counters = 0, debounced levels = 0.
//   FSM enters LOAD. Reset wins over every other event in the same cycle.
// - Inputs: btn_next, btn_prev and auto_en each pass through a 2-FF synchroniser.
// - Debounce: a per-button counter is cleared whenever the synchronised level equals the
//   debounced level. When it reaches DEBOUNCE_CYCLES-1 while the levels differ, the debounced
//   level flips. A debounced 0->1 flip makes a 1-cycle step pulse. A release makes none.
// - Step arbitration in cycle N:
//   - next only -> addr+1.
//   - prev only -> addr-1.
//   - next and prev together -> no step; both pulses are discarded.
//   - Any button step preempts auto-scan in the same cycle and clears scan_cnt.
// - Auto-scan: scan_cnt counts only while synchronised auto_en=1 and the FSM is not in LOAD.
//   At SCAN_PERIOD-1 it forces an addr+1 step and clears. auto_en=0 holds scan_cnt at 0.
// - Arithmetic: modulo 2**ADDR_WIDTH.
//   - Max+1 -> 0 and 0-1 -> max; either wrap asserts wrap in the cycle imem_addr takes the new value.
//   - No other event asserts wrap.
// - FSM states LOAD, SHOW_LO, SHOW_HI:
//   - LOAD: capture word_q<=imem_rdata; half_sel<=0; half_cnt<=0 -> SHOW_LO. If a step is also
//     accepted this cycle, update the address and stay in LOAD.
//   - SHOW_LO: half_cnt counts. At HALF_PERIOD-1 it clears, half_sel<=1 -> SHOW_HI.
//   - SHOW_HI: same count; at HALF_PERIOD-1 it clears, half_sel<=0 -> SHOW_LO.
//   - Any accepted step in SHOW_LO/SHOW_HI updates imem_addr and -> LOAD.
// - Latency: a step pulse in cycle N gives the new imem_addr in N+1 (state LOAD).
//   word_q holds the new word in N+2; displayed_number shows the new low half from N+2.
// - Between steps, displayed_number changes only on half toggles. IMem data changing without
//   a step is not re-captured.
// TESTING (sim params DEBOUNCE_CYCLES=4, SCAN_PERIOD=20, HALF_PERIOD=8, ADDR_WIDTH=6)
// - Reset, IMem[0]=32'hDEAD_BEEF -> imem_addr=0, wrap=0. Two cycles after reset,
//   displayed_number=16'hBEEF; after 8 more cycles, 16'hDEAD with half_sel=1.
// - btn_next held 10 cycles -> exactly one step, imem_addr=1.
//   Glitch high for 3 cycles -> no step. Release -> no step.
// - imem_addr=63, press next -> imem_addr=0 with wrap=1 for one cycle.
//   Then press prev -> imem_addr=63 with wrap=1 for one cycle.
// - next and prev debounced in the same cycle at addr=5 -> imem_addr stays 5, wrap=0, FSM stays in SHOW_*.
// - auto_en=1 from addr=0 -> addr increments every 21 cycles (20 + LOAD).
//   A next press mid-period gives one step and restarts the 20-cycle count.
// - Reset asserted in SHOW_HI at addr=9 -> next cycle imem_addr=0, half_sel=0, state LOAD.

Source files
------------

// File: rtl/imem_browse_ctrl.sv
// IMem browser: debounced next/prev stepping, optional auto-scan, and
// a latched 32-bit word shown as alternating 16-bit halves.
// Ports:
//   i_clk, i_reset            : clock, synchronous active-high reset
//   i_btn_next, i_btn_prev    : raw buttons (step +1 / -1)
//   i_auto_en                 : auto-scan enable level
//   o_imem_addr, i_imem_rdata : IMem word address / combinational data
//   o_displayed_number        : selected half of the latched word
//   o_half_sel                : 0 = low half shown, 1 = high half
//   o_wrap                    : one-cycle pulse on address wrap
module imem_browse_ctrl #(
  parameter int ADDR_WIDTH      = 6,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int SCAN_PERIOD     = 100_000_000,
  parameter int HALF_PERIOD     = 50_000_000
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_btn_next,
  input  logic                  i_btn_prev,
  input  logic                  i_auto_en,
  output logic [ADDR_WIDTH-1:0] o_imem_addr,
  input  logic [31:0]           i_imem_rdata,
  output logic [15:0]           o_displayed_number,
  output logic                  o_half_sel,
  output logic                  o_wrap
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam int SW = $clog2(SCAN_PERIOD);
  localparam int HW = $clog2(HALF_PERIOD);
  localparam logic [DW-1:0] DMAX = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [SW-1:0] SMAX = SW'(SCAN_PERIOD - 1);
  localparam logic [HW-1:0] HMAX = HW'(HALF_PERIOD - 1);

  typedef enum logic [1:0] {
    LOAD    = 2'd0,
    SHOW_LO = 2'd1,
    SHOW_HI = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next;

  // bit 0 = next, bit 1 = prev, bit 2 = auto_en
  logic [2:0] r_s1;
  logic [2:0] r_s2;

  logic [1:0]    r_db;
  logic [DW-1:0] r_dcnt [2];
  logic [1:0]    w_rise;

  logic [SW-1:0]         r_scan_cnt;
  logic [HW-1:0]         r_half_cnt;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [31:0]           r_word;
  logic                  r_half_sel;
  logic                  r_wrap;

  logic w_up_btn;
  logic w_dn;
  logic w_btn;
  logic w_scan_hit;
  logic w_up;
  logic w_step;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= {i_auto_en, i_btn_prev, i_btn_next};
      r_s2 <= r_s1;
    end
  end

  // Rising debounced edge is seen in the same cycle the level flips.
  always_comb begin
    w_rise = '0;
    for (int i = 0; i < 2; i++) begin
      w_rise[i] = r_s2[i] & ~r_db[i] & (r_dcnt[i] == DMAX);
    end
  end

  always_ff @(posedge i_clk) begin
    for (int i = 0; i < 2; i++) begin
      if (i_reset) begin
        r_db[i]   <= 1'b0;
        r_dcnt[i] <= '0;
      end else if (r_s2[i] == r_db[i]) begin
        r_dcnt[i] <= '0;
      end else if (r_dcnt[i] == DMAX) begin
        r_db[i]   <= r_s2[i];
        r_dcnt[i] <= '0;
      end else begin
        r_dcnt[i] <= r_dcnt[i] + 1'b1;
      end
    end
  end

  // Simultaneous next+prev cancel out and count as no button activity.
  assign w_up_btn   = w_rise[0] & ~w_rise[1];
  assign w_dn       = w_rise[1] & ~w_rise[0];
  assign w_btn      = w_up_btn | w_dn;
  assign w_scan_hit = r_s2[2] & (r_state != LOAD)
                    & (r_scan_cnt == SMAX) & ~w_btn;
  assign w_up       = w_up_btn | w_scan_hit;
  assign w_step     = w_up | w_dn;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_scan_cnt <= '0;
    end else if (w_btn || !r_s2[2]) begin
      r_scan_cnt <= '0;
    end else if (r_state != LOAD) begin
      if (r_scan_cnt == SMAX) r_scan_cnt <= '0;
      else                    r_scan_cnt <= r_scan_cnt + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_addr <= '0;
      r_wrap <= 1'b0;
    end else begin
      r_wrap <= (w_up && (r_addr == '1)) || (w_dn && (r_addr == '0));
      if (w_up)      r_addr <= r_addr + 1'b1;
      else if (w_dn) r_addr <= r_addr - 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= LOAD;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      LOAD:    w_next = w_step ? LOAD : SHOW_LO;
      SHOW_LO: begin
        if (w_step)                  w_next = LOAD;
        else if (r_half_cnt == HMAX) w_next = SHOW_HI;
      end
      SHOW_HI: begin
        if (w_step)                  w_next = LOAD;
        else if (r_half_cnt == HMAX) w_next = SHOW_LO;
      end
      default: w_next = LOAD;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_word     <= '0;
      r_half_sel <= 1'b0;
      r_half_cnt <= '0;
    end else if (r_state == LOAD) begin
      r_word     <= i_imem_rdata;
      r_half_sel <= 1'b0;
      r_half_cnt <= '0;
    end else if (!w_step) begin
      if (r_half_cnt == HMAX) begin
        r_half_cnt <= '0;
        r_half_sel <= (r_state == SHOW_LO);
      end else begin
        r_half_cnt <= r_half_cnt + 1'b1;
      end
    end
  end

  assign o_imem_addr        = r_addr;
  assign o_wrap             = r_wrap;
  assign o_half_sel         = r_half_sel;
  assign o_displayed_number = r_half_sel ? r_word[31:16] : r_word[15:0];

endmodule

// File: tb/tb_imem_browse_ctrl.sv
// Bench for imem_browse_ctrl: event-level reference model checked every
// cycle, plus directed literal expectations on key scenarios.
module tb_imem_browse_ctrl;

  localparam int AW   = 6;
  localparam int DEB  = 4;
  localparam int SCAN = 20;
  localparam int HALF = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          bn;
  logic          bp;
  logic          ae;
  logic [AW-1:0] addr;
  logic [31:0]   rdata;
  logic [15:0]   disp;
  logic          half;
  logic          wrap;
  logic [31:0]   mem [64];

  assign rdata = mem[addr];

  always #5 clk = ~clk;

  imem_browse_ctrl #(
    .ADDR_WIDTH      (AW),
    .DEBOUNCE_CYCLES (DEB),
    .SCAN_PERIOD     (SCAN),
    .HALF_PERIOD     (HALF)
  ) dut (
    .i_clk              (clk),
    .i_reset            (reset),
    .i_btn_next         (bn),
    .i_btn_prev         (bp),
    .i_auto_en          (ae),
    .o_imem_addr        (addr),
    .i_imem_rdata       (rdata),
    .o_displayed_number (disp),
    .o_half_sel         (half),
    .o_wrap             (wrap)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc_cnt = 0;
  int w_cnt   = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: raw inputs are seen two edges late; a button is
  // accepted once its level differs from the accepted level for DEB
  // consecutive edges; only presses step.
  bit          m_valid = 1'b0;
  int          m_addr;
  logic [31:0] m_word;
  bit          m_half;
  bit          m_wrap;
  bit          m_loading;
  int          m_t;
  int          m_scan;
  bit [2:0]    h1;
  bit [2:0]    h2;
  bit [1:0]    m_db;
  int          m_run [2];

  always @(posedge clk) begin
    bit [2:0] raw;
    bit [2:0] sy;
    bit [1:0] pulse;
    int       delta;
    int       na;
    raw = {ae, bp, bn};
    if (reset) begin
      m_valid   = 1'b1;
      m_addr    = 0;
      m_word    = '0;
      m_half    = 1'b0;
      m_wrap    = 1'b0;
      m_loading = 1'b1;
      m_t       = 0;
      m_scan    = 0;
      h1        = '0;
      h2        = '0;
      m_db      = '0;
      m_run[0]  = 0;
      m_run[1]  = 0;
    end else if (m_valid) begin
      sy    = h2;
      pulse = '0;
      for (int i = 0; i < 2; i++) begin
        if (sy[i] != m_db[i]) begin
          m_run[i]++;
          if (m_run[i] == DEB) begin
            m_db[i]  = sy[i];
            m_run[i] = 0;
            pulse[i] = sy[i];
          end
        end else begin
          m_run[i] = 0;
        end
      end
      delta = int'(pulse[0]) - int'(pulse[1]);
      if (delta != 0 || !sy[2]) begin
        m_scan = 0;
      end else if (!m_loading) begin
        m_scan++;
        if (m_scan == SCAN) begin
          m_scan = 0;
          delta  = 1;
        end
      end
      if (m_loading) begin
        m_word    = mem[m_addr];
        m_t       = 0;
        m_half    = 1'b0;
        m_loading = (delta != 0);
      end else if (delta != 0) begin
        m_loading = 1'b1;
      end else begin
        m_t++;
        m_half = ((m_t / HALF) % 2) == 1;
      end
      na     = m_addr + delta;
      m_wrap = (na < 0) || (na >= 64);
      m_addr = (na + 64) % 64;
      h2     = h1;
      h1     = raw;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("addr", 32'(addr), 32'(m_addr));
      chk("wrap", 32'(wrap), 32'(m_wrap));
      chk("half_sel", 32'(half), 32'(m_half));
      chk("disp", 32'(disp),
          32'(m_half ? m_word[31:16] : m_word[15:0]));
      if (wrap === 1'b1) w_cnt++;
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge clk);
      cyc_cnt++;
    end
  endtask

  task automatic press(input bit nx, input bit pv, input int hold);
    bn = nx;
    bp = pv;
    cyc(hold);
    bn = 1'b0;
    bp = 1'b0;
    cyc(10);
  endtask

  task automatic wait_change(output int stamp);
    logic [AW-1:0] a0;
    a0    = addr;
    stamp = -1;
    for (int i = 0; i < 40; i++) begin
      cyc(1);
      if (addr !== a0) begin
        stamp = cyc_cnt;
        return;
      end
    end
    n_tests++;
    n_fail++;
    $display("FAIL wait_change: addr stuck at %0d", a0);
  endtask

  int t0;
  int t1;
  int tb_s;
  int ta;

  initial begin
    for (int i = 0; i < 64; i++) begin
      mem[i] = (32'(i) * 32'h0001_0001) ^ 32'hA5A5_5A5A;
    end
    mem[0] = 32'hDEAD_BEEF;
    reset = 1'b1;
    bn    = 1'b0;
    bp    = 1'b0;
    ae    = 1'b0;
    cyc(2);
    chk("rst_addr", 32'(addr), 32'd0);
    chk("rst_wrap", 32'(wrap), 32'd0);
    chk("rst_disp", 32'(disp), 32'd0);
    reset = 1'b0;
    cyc(1);
    chk("load_lo", 32'(disp), 32'hBEEF);
    cyc(7);
    chk("still_lo", 32'(disp), 32'hBEEF);
    cyc(1);
    chk("show_hi", 32'(disp), 32'hDEAD);
    chk("show_hi_sel", 32'(half), 32'd1);

    press(1'b1, 1'b0, 10);
    chk("next_once", 32'(addr), 32'd1);
    press(1'b1, 1'b0, 3);
    chk("glitch", 32'(addr), 32'd1);
    chk("no_wrap_yet", 32'(w_cnt), 32'd0);
    press(1'b0, 1'b1, 10);
    chk("prev_to0", 32'(addr), 32'd0);
    press(1'b0, 1'b1, 10);
    chk("prev_wrap", 32'(addr), 32'd63);
    chk("wrap_cnt1", 32'(w_cnt), 32'd1);
    press(1'b1, 1'b0, 10);
    chk("next_wrap", 32'(addr), 32'd0);
    chk("wrap_cnt2", 32'(w_cnt), 32'd2);
    press(1'b0, 1'b1, 10);
    chk("prev_wrap2", 32'(addr), 32'd63);
    chk("wrap_cnt3", 32'(w_cnt), 32'd3);
    for (int k = 0; k < 6; k++) press(1'b1, 1'b0, 10);
    chk("at5", 32'(addr), 32'd5);
    chk("wrap_cnt4", 32'(w_cnt), 32'd4);
    press(1'b1, 1'b1, 10);
    chk("both", 32'(addr), 32'd5);
    chk("both_wrap", 32'(w_cnt), 32'd4);

    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    ae    = 1'b1;
    wait_change(t0);
    chk("auto1", 32'(addr), 32'd1);
    wait_change(t1);
    chk("auto2", 32'(addr), 32'd2);
    chk("auto_period", 32'(t1 - t0), 32'd21);
    cyc(10);
    bn = 1'b1;
    wait_change(tb_s);
    chk("auto_btn", 32'(addr), 32'd3);
    cyc(4);
    bn = 1'b0;
    wait_change(ta);
    chk("auto4", 32'(addr), 32'd4);
    chk("restart_period", 32'(ta - tb_s), 32'd21);
    for (int k = 0; k < 6 && addr != 6'd9; k++) wait_change(ta);
    chk("auto9", 32'(addr), 32'd9);
    ae = 1'b0;
    for (int k = 0; k < 40 && half !== 1'b1; k++) cyc(1);
    chk("hi_at9", 32'(half), 32'd1);
    chk("hi_at9_disp", 32'(disp), 32'(mem[9][31:16]));
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    chk("rst9_addr", 32'(addr), 32'd0);
    chk("rst9_half", 32'(half), 32'd0);
    chk("rst9_disp", 32'(disp), 32'd0);
    cyc(1);
    chk("rst9_load", 32'(disp), 32'hBEEF);
    cyc(5);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
